// File: rtl/GPU_Shader_pkg.sv
// Shared shader-core types: lane count, memory size, word type and the store request record.
package GPU_Shader_pkg;

  localparam int LANES      = 4;
  localparam int MEM_DEPTH  = 256;
  localparam int WORD_WIDTH = 32;

  // One extra address bit so a producer can express a store that falls outside the memory.
  localparam int REQ_ADDR_WIDTH = $clog2(MEM_DEPTH) + 1;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef struct packed {
    logic [LANES-1:0]                     mask;
    logic [LANES-1:0][REQ_ADDR_WIDTH-1:0] addr;
    word_t [LANES-1:0]                    data;
  } store_req_t;

endpackage

// File: rtl/store_drain_queue_if.sv
// Store request channel (valid/ready) plus the memory write port it drains into.
interface store_drain_queue_if import GPU_Shader_pkg::*; #(
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) ();

  // A request transfers at a posedge where in_valid && in_ready; in_valid and the payload
  // must hold until then. The write port has no ready: the memory always accepts write_*.
  logic                                 in_valid;
  logic                                 in_ready;
  logic [LANES-1:0]                     in_mask;
  logic [LANES-1:0][ADDR_WIDTH-1:0]     in_addr;
  word_t [LANES-1:0]                    in_data;
  logic [LANES-1:0]                     write_en;
  logic [LANES-1:0][ADDR_WIDTH-1:0]     write_addr;
  word_t [LANES-1:0]                    write_data;

  modport master (
    output in_valid, in_mask, in_addr, in_data,
    input  in_ready, write_en, write_addr, write_data
  );

  modport slave (
    input  in_valid, in_mask, in_addr, in_data,
    output in_ready, write_en, write_addr, write_data
  );

endinterface

// File: rtl/lane_store_resolve.sv
// Decides which masked lanes of one store actually write: drops out-of-range lanes and lanes
// overwritten by a higher lane targeting the same address.
module lane_store_resolve import GPU_Shader_pkg::*; #(
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic [LANES-1:0]                 mask,
  input  logic [LANES-1:0][ADDR_WIDTH-1:0] addr,
  output logic [LANES-1:0]                 en,
  output logic                             oob
);

  always_comb begin
    en  = '0;
    oob = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        if (32'(addr[i]) >= MEM_DEPTH) begin
          oob = 1'b1;
        end else begin
          en[i] = 1'b1;
          for (int j = i + 1; j < LANES; j++) begin
            if (mask[j] && (addr[j] == addr[i])) en[i] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_drain_queue.sv
// Small FIFO of lane stores that drains one entry per cycle into a registered memory write port.
module store_drain_queue import GPU_Shader_pkg::*; #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  store_drain_queue_if.slave bus,
  input  logic              clr_err,
  output logic              busy,
  output logic              oob_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LANES-1:0]                 mask_mem [DEPTH];
  logic [LANES-1:0][ADDR_WIDTH-1:0] addr_mem [DEPTH];
  word_t [LANES-1:0]                data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [LANES-1:0] head_en;
  logic             head_oob;

  // Ready looks only at the registered count, so a full queue refuses even when it pops.
  assign bus.in_ready = (count < CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (count != '0);
  assign busy         = pop || (|bus.write_en);

  lane_store_resolve #(.ADDR_WIDTH(ADDR_WIDTH)) u_resolve (
    .mask (mask_mem[rd_ptr]),
    .addr (addr_mem[rd_ptr]),
    .en   (head_en),
    .oob  (head_oob)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr] <= bus.in_mask;
      addr_mem[wr_ptr] <= bus.in_addr;
      data_mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      bus.write_addr <= addr_mem[rd_ptr];
      bus.write_data <= data_mem[rd_ptr];
    end
  end

  // Pointers are log2(DEPTH) bits wide, so plain increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.write_en <= '0;
      oob_err      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count        <= count + CNT_W'(push) - CNT_W'(pop);
      bus.write_en <= pop ? head_en : '0;
      if (pop && head_oob) oob_err <= 1'b1;
      else if (clr_err)    oob_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_store_drain_queue.sv
// Random and directed stimulus for store_drain_queue against a queue-based reference model.
module tb_store_drain_queue;
  import GPU_Shader_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = REQ_ADDR_WIDTH;

  logic clk;
  logic rst;
  logic clr_err;
  logic busy;
  logic oob_err;

  store_drain_queue_if #(.ADDR_WIDTH(AW)) bus ();

  store_drain_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clr_err (clr_err),
    .busy    (busy),
    .oob_err (oob_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: request queue, expected write port, expected error flag, memory images
  store_req_t       model_q[$];
  store_req_t       exp_head;
  logic [LANES-1:0] exp_we = '0;
  logic             exp_oob = 1'b0;
  word_t            ref_mem [MEM_DEPTH];
  word_t            dut_mem [MEM_DEPTH];
  logic [LANES-1:0]            cap_we = '0;
  logic [LANES-1:0][AW-1:0]    cap_wa;
  word_t [LANES-1:0]           cap_wd;

  initial begin
    for (int a = 0; a < MEM_DEPTH; a++) begin
      ref_mem[a] = '0;
      dut_mem[a] = '0;
    end
  end

  function automatic bit lane_in_range(input store_req_t r, input int i);
    return r.mask[i] && (int'(r.addr[i]) < MEM_DEPTH);
  endfunction

  // A lane writes if it is the last in-range masked lane (in lane order) to touch its address.
  function automatic logic [LANES-1:0] effective_writes(input store_req_t r);
    logic [LANES-1:0] we;
    int last;
    we = '0;
    for (int i = 0; i < LANES; i++) begin
      last = -1;
      for (int j = 0; j < LANES; j++)
        if (lane_in_range(r, j) && r.addr[j] == r.addr[i]) last = j;
      we[i] = lane_in_range(r, i) && (last == i);
    end
    return we;
  endfunction

  always @(posedge clk) begin
    store_req_t in_r;
    bit         do_push;
    bit         oob_hit;
    in_r.mask = bus.in_mask;
    in_r.addr = bus.in_addr;
    in_r.data = bus.in_data;
    for (int i = 0; i < LANES; i++) begin
      if (exp_we[i]) ref_mem[int'(exp_head.addr[i])] = exp_head.data[i];
      if (cap_we[i]) dut_mem[int'(cap_wa[i])] = cap_wd[i];
    end
    if (rst) begin
      model_q.delete();
      exp_we  = '0;
      exp_oob = 1'b0;
    end else begin
      do_push = bus.in_valid && (model_q.size() < DEPTH);
      oob_hit = 1'b0;
      exp_we  = '0;
      if (model_q.size() > 0) begin
        exp_head = model_q.pop_front();
        exp_we   = effective_writes(exp_head);
        for (int i = 0; i < LANES; i++)
          if (exp_head.mask[i] && int'(exp_head.addr[i]) >= MEM_DEPTH) oob_hit = 1'b1;
      end
      if (do_push) model_q.push_back(in_r);
      if (oob_hit)      exp_oob = 1'b1;
      else if (clr_err) exp_oob = 1'b0;
    end
    #2;
    check("in_ready", 64'(bus.in_ready), 64'(model_q.size() < DEPTH));
    check("write_en", 64'(bus.write_en), 64'(exp_we));
    check("busy", 64'(busy), 64'((model_q.size() != 0) || (|exp_we)));
    check("oob_err", 64'(oob_err), 64'(exp_oob));
    for (int i = 0; i < LANES; i++) begin
      if (exp_we[i]) begin
        check($sformatf("write_addr[%0d]", i), 64'(bus.write_addr[i]), 64'(exp_head.addr[i]));
        check($sformatf("write_data[%0d]", i), 64'(bus.write_data[i]), 64'(exp_head.data[i]));
      end
    end
    cap_we = bus.write_en;
    cap_wa = bus.write_addr;
    cap_wd = bus.write_data;
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push(input logic [LANES-1:0] m, input int a0, input int a1, input int a2,
                      input int a3, input word_t d0, input word_t d1, input word_t d2,
                      input word_t d3);
    int waited;
    waited = 0;
    bus.in_valid   = 1'b1;
    bus.in_mask    = m;
    bus.in_addr[0] = AW'(a0);
    bus.in_addr[1] = AW'(a1);
    bus.in_addr[2] = AW'(a2);
    bus.in_addr[3] = AW'(a3);
    bus.in_data[0] = d0;
    bus.in_data[1] = d1;
    bus.in_data[2] = d2;
    bus.in_data[3] = d3;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", waited);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int mism;
    rst          = 1'b1;
    clr_err      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    idle(2);
    rst = 1'b0;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_write_en", 64'(bus.write_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_oob_err", 64'(oob_err), 64'd0);

    // single full-mask store: visible one cycle after the pop edge, committed the edge after
    push(4'b1111, 1, 2, 3, 4, 32'hA, 32'hB, 32'hC, 32'hD);
    check("single_wait_write_en", 64'(bus.write_en), 64'd0);
    idle(1);
    check("single_write_en", 64'(bus.write_en), 64'hF);
    idle(1);
    check("single_busy_low", 64'(busy), 64'd0);
    check("single_mem1", 64'(dut_mem[1]), 64'hA);
    check("single_mem4", 64'(dut_mem[4]), 64'hD);

    // back-to-back pushes drain in push order
    for (int k = 0; k < 5; k++)
      push(4'b0001, 20 + k, 0, 0, 0, word_t'(32'h100 + k), 0, 0, 0);
    idle(3);
    check("order_mem24", 64'(dut_mem[24]), 64'h104);
    check("order_mem20", 64'(dut_mem[20]), 64'h100);

    // same-address lanes: highest masked lane wins
    push(4'b1011, 7, 9, 7, 7, 32'h70, 32'h91, 32'h72, 32'h73);
    idle(1);
    check("conflict_write_en", 64'(bus.write_en), 64'hA);
    idle(1);
    check("conflict_mem7", 64'(dut_mem[7]), 64'h73);
    check("conflict_mem9", 64'(dut_mem[9]), 64'h91);

    // out-of-range lane: sticky error, clear, and set beating clear
    push(4'b0100, 0, 0, 300, 0, 0, 0, 32'hBAD, 0);
    idle(1);
    check("oob_write_en", 64'(bus.write_en), 64'd0);
    check("oob_set", 64'(oob_err), 64'd1);
    idle(3);
    check("oob_held", 64'(oob_err), 64'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("oob_cleared", 64'(oob_err), 64'd0);
    push(4'b0100, 0, 0, 400, 0, 0, 0, 32'hBAD, 0);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check("oob_set_wins", 64'(oob_err), 64'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;

    // reset in the middle of a stream discards what is queued
    push(4'b0001, 40, 0, 0, 0, 32'h40, 0, 0, 0);
    push(4'b0001, 41, 0, 0, 0, 32'h41, 0, 0, 0);
    push(4'b0001, 50, 0, 0, 0, 32'h50, 0, 0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_write_en", 64'(bus.write_en), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    idle(3);
    check("rst_discarded_mem50", 64'(dut_mem[50]), 64'd0);

    // randomized traffic with dense address collisions and occasional errors/resets
    for (int c = 0; c < 600; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_mask  = LANES'($urandom_range(0, 15));
      for (int i = 0; i < LANES; i++) begin
        bus.in_addr[i] = ($urandom_range(0, 15) == 0) ? AW'($urandom_range(256, 511))
                                                      : AW'($urandom_range(0, 15));
        bus.in_data[i] = word_t'($urandom);
      end
      clr_err = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      idle(1);
    end
    bus.in_valid = 1'b0;
    clr_err      = 1'b0;
    rst          = 1'b0;
    idle(4);

    mism = 0;
    for (int a = 0; a < MEM_DEPTH; a++)
      if (dut_mem[a] !== ref_mem[a]) mism++;
    check("mem_image_mismatches", 64'(mism), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
